// File: rtl/ds1124_pkg.sv
// Shared definitions for the DS1124 3-wire interface: data width, settle time,
// state encoding and the settle-cycle calculation used by driver and target.
package ds1124_pkg;

    localparam int DS1124_DATA_W    = 8;
    localparam int DS1124_SETTLE_US = 50;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_SETTLE
    } state_t;

    function automatic int settle_cycles(input int freq, input int us);
        return (freq / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ds1124_sync_edge.sv
// Multi-stage synchronizer for one asynchronous serial line, with rise/fall
// detection against the previous synchronized value. STAGES must be >= 2.
module ds1124_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ds1124_target.sv
// DS1124 serial responder: shifts a frame in while E is high, drives Q from the
// shift register MSB, latches the delay code on E falling and times settling.
module ds1124_target
    import ds1124_pkg::*;
#(
    parameter int                       SYS_CLK_FREQ   = 100_000_000,
    parameter int                       SETTLE_TIME_US = DS1124_SETTLE_US,
    parameter int                       SYNC_STAGES    = 2,
    parameter logic [DS1124_DATA_W-1:0] INIT_CODE      = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ds1124_clk,
    input  logic                     ds1124_d,
    input  logic                     ds1124_e,
    output logic                     ds1124_q,
    output logic [DS1124_DATA_W-1:0] delay_code,
    output logic                     code_update,
    output logic                     settling,
    output logic                     frame_err
);

    localparam int SETTLE_CYCLES = settle_cycles(SYS_CLK_FREQ, SETTLE_TIME_US);
    localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1);
    localparam int ARM_W         = $clog2(SYNC_STAGES + 2);
    localparam int DW            = DS1124_DATA_W;

    logic clk_level, clk_rise, clk_fall;
    logic d_level, d_rise, d_fall;
    logic e_level, e_rise, e_fall;
    logic unused_edges;

    ds1124_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst(rst), .din(ds1124_clk),
        .level(clk_level), .rise(clk_rise), .fall(clk_fall)
    );

    ds1124_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_d (
        .clk(clk), .rst(rst), .din(ds1124_d),
        .level(d_level), .rise(d_rise), .fall(d_fall)
    );

    ds1124_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_e (
        .clk(clk), .rst(rst), .din(ds1124_e),
        .level(e_level), .rise(e_rise), .fall(e_fall)
    );

    assign unused_edges = ^{clk_level, clk_fall, d_rise, d_fall, e_level};

    state_t           state_q, state_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [DW-1:0]    code_q, code_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic             settling_q, settling_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic             q_q;
    logic [DW-1:0]    shift_next;
    logic [3:0]       bit_cnt_next;
    logic             armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= INIT_CODE;
            code_q     <= INIT_CODE;
            bit_cnt_q  <= '0;
            cnt_q      <= '0;
            arm_q      <= ARM_W'(SYNC_STAGES + 1);
            settling_q <= 1'b0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
            q_q        <= INIT_CODE[DW-1];
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            code_q     <= code_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            arm_q      <= arm_d;
            settling_q <= settling_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
            q_q        <= shift_q[DW-1];
        end
    end

    // Edges seen while the cleared synchronizers refill after reset are
    // spurious (E may still be high from an aborted frame), so they are masked.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        code_d       = code_q;
        bit_cnt_d    = bit_cnt_q;
        cnt_d        = cnt_q;
        settling_d   = settling_q;
        upd_d        = 1'b0;
        err_d        = 1'b0;
        armed        = (arm_q == '0);
        arm_d        = armed ? arm_q : arm_q - 1'b1;
        shift_next   = shift_q;
        bit_cnt_next = bit_cnt_q;

        if (settling_q) begin
            if (cnt_q == '0) begin
                settling_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_SETTLE: begin
                if (armed && e_rise) begin
                    state_d   = ST_FRAME;
                    shift_d   = code_q;
                    bit_cnt_d = '0;
                end else if (state_q == ST_SETTLE && !settling_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (clk_rise) begin
                    shift_next   = {shift_q[DW-2:0], d_level};
                    bit_cnt_next = (bit_cnt_q == 4'd15) ? 4'd15 : bit_cnt_q + 4'd1;
                end
                shift_d   = shift_next;
                bit_cnt_d = bit_cnt_next;
                // The latch sees the shift applied in this same cycle.
                if (e_fall) begin
                    state_d    = ST_SETTLE;
                    code_d     = shift_next;
                    upd_d      = 1'b1;
                    err_d      = (bit_cnt_next != 4'd8);
                    settling_d = 1'b1;
                    cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ds1124_q    = q_q;
    assign delay_code  = code_q;
    assign code_update = upd_q;
    assign settling    = settling_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_ds1124_target.sv
// Randomized self-checking bench for ds1124_target against a frame-level model
// of the delay code (old code concatenated with the shifted bits, last 8 kept).
module tb_ds1124_target;

    localparam int HALF      = 6;
    localparam int SETTLE    = 5000;
    localparam int LATCH_LAT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ds_clk, ds_d, ds_e;
    logic       ds_q;
    logic [7:0] delay_code;
    logic       code_update, settling, frame_err;

    int          checks = 0;
    int          errors = 0;
    int          updCnt = 0;
    int          errCnt = 0;
    int          run = 0;
    int          lastRun = 0;
    logic        prevSettling = 1'b0;
    logic [7:0]  refCode;
    logic [15:0] qSeen;

    ds1124_target #(
        .SYS_CLK_FREQ(100_000_000),
        .SETTLE_TIME_US(50),
        .SYNC_STAGES(2),
        .INIT_CODE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ds1124_clk(ds_clk),
        .ds1124_d(ds_d),
        .ds1124_e(ds_e),
        .ds1124_q(ds_q),
        .delay_code(delay_code),
        .code_update(code_update),
        .settling(settling),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters and settle-window length measured from the outputs.
    always @(negedge clk) begin
        updCnt       <= updCnt + (code_update ? 1 : 0);
        errCnt       <= errCnt + (frame_err ? 1 : 0);
        run          <= code_update ? 1 : (settling ? run + 1 : run);
        lastRun      <= (!settling && prevSettling) ? run : lastRun;
        prevSettling <= settling;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic serialBit(input logic b);
        ds_d = b;
        tick(HALF);
        ds_clk = 1'b1;
        tick(HALF);
        ds_clk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] bits, input int n, input bit loopback);
        ds_e = 1'b1;
        tick(HALF);
        for (int i = 0; i < n; i++) begin
            qSeen[i] = ds_q;
            serialBit(loopback ? ds_q : bits[n-1-i]);
        end
        tick(HALF);
        ds_e = 1'b0;
        tick(LATCH_LAT);
    endtask

    task automatic runFrame(input string tag, input logic [15:0] bits, input int n, input bit loopback);
        int          u0 = updCnt;
        int          e0 = errCnt;
        logic [31:0] mask;
        logic [31:0] seq;
        logic [15:0] b;
        b    = loopback ? {8'h00, refCode} : bits;
        mask = (32'd1 << n) - 32'd1;
        seq  = ({24'h0, refCode} << n) | ({16'h0, b} & mask);
        applyStimulus(bits, n, loopback);
        for (int i = 0; i < n; i++)
            checkOutput({tag, "_q"}, {31'h0, qSeen[i]}, {31'h0, seq[n+7-i]});
        refCode = seq[7:0];
        checkOutput({tag, "_code"}, {24'h0, delay_code}, {24'h0, refCode});
        checkOutput({tag, "_upd"}, updCnt - u0, 1);
        checkOutput({tag, "_err"}, errCnt - e0, (n != 8) ? 1 : 0);
    endtask

    task automatic waitSettle(input string tag);
        for (int i = 0; i < 12000 && settling; i++) tick(1);
        checkOutput({tag, "_settle_done"}, {31'h0, settling}, 0);
        tick(2);
        checkOutput({tag, "_settle_len"}, lastRun, SETTLE);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int u0;
        int e0;
        rst     = 1'b1;
        ds_clk  = 1'b0;
        ds_d    = 1'b0;
        ds_e    = 1'b0;
        refCode = 8'h00;
        tick(5);
        rst = 1'b0;
        tick(5);
        checkOutput("reset_code", {24'h0, delay_code}, 0);
        checkOutput("reset_q", {31'h0, ds_q}, 0);
        checkOutput("reset_upd", {31'h0, code_update}, 0);
        checkOutput("reset_settling", {31'h0, settling}, 0);
        checkOutput("reset_err", {31'h0, frame_err}, 0);

        runFrame("write_a5", 16'h00A5, 8, 1'b0);
        checkOutput("write_a5_settling", {31'h0, settling}, 1);
        waitSettle("write_a5");

        runFrame("preset_3c", 16'h003C, 8, 1'b0);
        runFrame("readback", 16'h0000, 8, 1'b1);

        runFrame("preset_ff", 16'h00FF, 8, 1'b0);
        runFrame("short", 16'h0000, 5, 1'b0);

        runFrame("long", 16'h0301, 10, 1'b0);

        runFrame("b2b_first", 16'h0010, 8, 1'b0);
        tick(1890);
        checkOutput("b2b_mid_settling", {31'h0, settling}, 1);
        runFrame("b2b_second", 16'h0020, 8, 1'b0);
        waitSettle("b2b");

        for (int k = 0; k < 8; k++) begin
            runFrame("rand", 16'($urandom), $urandom_range(1, 12), 1'b0);
            tick($urandom_range(10, 3000));
        end

        // Reset in the middle of a frame, with E still high when reset releases.
        u0   = updCnt;
        e0   = errCnt;
        ds_e = 1'b1;
        tick(HALF);
        for (int i = 0; i < 4; i++) serialBit(1'($urandom));
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        refCode = 8'h00;
        tick(1);
        checkOutput("midreset_code", {24'h0, delay_code}, 0);
        checkOutput("midreset_q", {31'h0, ds_q}, 0);
        checkOutput("midreset_settling", {31'h0, settling}, 0);
        for (int i = 0; i < 3; i++) serialBit(1'($urandom));
        tick(HALF);
        ds_e = 1'b0;
        tick(20);
        checkOutput("midreset_code_after_e", {24'h0, delay_code}, 0);
        checkOutput("midreset_q_after_e", {31'h0, ds_q}, 0);
        checkOutput("midreset_no_upd", updCnt - u0, 0);
        checkOutput("midreset_no_err", errCnt - e0, 0);

        runFrame("post_reset", 16'($urandom), 8, 1'b0);
        waitSettle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
